// File: rtl/cpu_exec_unit.sv
// Multi-cycle execute engine: register file, ALU, byte-lane immediates, memory port. Optional CPU_EXEC_TIMEOUT_EN adds a memory-wait limit.
// Latency accept->done: 2 cycles (ALU/MOV/LDLO/LDHI/NOP), 2 + memory wait cycles (LOAD/STORE).
// Backpressure: uop_ready only in IDLE; mem_re/mem_we held until mem_ack (or timeout when enabled).
module cpu_exec_unit #(
    parameter int WIDTH   = 16,
    parameter int NREGS   = 8,
    parameter int ADDR_W  = 16,
    parameter int TIMEOUT = 255,
    localparam int RW     = $clog2(NREGS)
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic              uop_valid,
    output logic              uop_ready,
    input  logic [2:0]        uop_kind,
    input  logic [2:0]        uop_op,
    input  logic [RW-1:0]     uop_ra,
    input  logic [RW-1:0]     uop_rb,
    input  logic [RW-1:0]     uop_rd,
    input  logic              uop_bsel,
    input  logic [WIDTH-1:0]  uop_imm,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [WIDTH-1:0]  mem_wdata,
    output logic              mem_re,
    output logic              mem_we,
    input  logic [WIDTH-1:0]  mem_rdata,
    input  logic              mem_ack,
    output logic              done,
    output logic              flag_z,
    output logic              flag_c,
    output logic              err,
    input  logic [RW-1:0]     dbg_raddr,
    output logic [WIDTH-1:0]  dbg_rdata
);

    typedef enum logic [1:0] {S_IDLE, S_EXEC, S_MEM, S_WB} state_t;

    localparam logic [2:0] K_ALU   = 3'd0;
    localparam logic [2:0] K_LOAD  = 3'd1;
    localparam logic [2:0] K_STORE = 3'd2;
    localparam logic [2:0] K_LDLO  = 3'd3;
    localparam logic [2:0] K_LDHI  = 3'd4;
    localparam logic [2:0] K_MOV   = 3'd5;

    localparam logic [2:0] OP_ADD  = 3'd0;
    localparam logic [2:0] OP_SUB  = 3'd1;
    localparam logic [2:0] OP_AND  = 3'd2;
    localparam logic [2:0] OP_OR   = 3'd3;
    localparam logic [2:0] OP_XOR  = 3'd4;
    localparam logic [2:0] OP_SHL1 = 3'd5;
    localparam logic [2:0] OP_SHR1 = 3'd6;

    state_t            state_q, state_d;
    logic [2:0]        kind_q, op_q;
    logic [RW-1:0]     rd_q;
    logic [WIDTH-1:0]  opa_q, opb_q, sdata_q, res_q, rdata_q;
    logic [7:0]        imm8_q;
    logic              flag_z_q, flag_c_q;
    logic [WIDTH-1:0]  regs [NREGS];

    logic              is_mem;
    logic [2:0]        op_eff;
    logic [WIDTH:0]    sum;
    logic [WIDTH-1:0]  alu_res;
    logic              alu_c;
    logic              tmo_hit;
    logic              wb_skip;

    assign is_mem = (kind_q == K_LOAD) || (kind_q == K_STORE);
    // Address generation reuses the adder.
    assign op_eff = is_mem ? OP_ADD : op_q;

    always_comb begin
        sum     = '0;
        alu_res = '0;
        alu_c   = 1'b0;
        case (op_eff)
            OP_ADD: begin
                sum     = {1'b0, opa_q} + {1'b0, opb_q};
                alu_res = sum[WIDTH-1:0];
                alu_c   = sum[WIDTH];
            end
            OP_SUB: begin
                alu_res = opa_q - opb_q;
                alu_c   = (opa_q >= opb_q);
            end
            OP_AND:  alu_res = opa_q & opb_q;
            OP_OR:   alu_res = opa_q | opb_q;
            OP_XOR:  alu_res = opa_q ^ opb_q;
            OP_SHL1: begin
                alu_res = {opa_q[WIDTH-2:0], 1'b0};
                alu_c   = opa_q[WIDTH-1];
            end
            OP_SHR1: begin
                alu_res = {1'b0, opa_q[WIDTH-1:1]};
                alu_c   = opa_q[0];
            end
            default: alu_res = opb_q;
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) state_q <= S_IDLE;
        else          state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE: if (uop_valid) state_d = S_EXEC;
            S_EXEC: state_d = is_mem ? S_MEM : S_WB;
            S_MEM:  if (mem_ack || tmo_hit) state_d = S_WB;
            default: state_d = S_IDLE;
        endcase
    end

    assign uop_ready = (state_q == S_IDLE);
    assign done      = (state_q == S_WB);
    assign mem_re    = (state_q == S_MEM) && (kind_q == K_LOAD);
    assign mem_we    = (state_q == S_MEM) && (kind_q == K_STORE);
    assign mem_addr  = (state_q == S_MEM) ? res_q[ADDR_W-1:0] : '0;
    assign mem_wdata = (state_q == S_MEM) ? sdata_q : '0;
    assign flag_z    = flag_z_q;
    assign flag_c    = flag_c_q;
    assign dbg_rdata = regs[dbg_raddr];

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            kind_q   <= '0;
            op_q     <= '0;
            rd_q     <= '0;
            opa_q    <= '0;
            opb_q    <= '0;
            sdata_q  <= '0;
            imm8_q   <= '0;
            res_q    <= '0;
            rdata_q  <= '0;
            flag_z_q <= 1'b0;
            flag_c_q <= 1'b0;
        end else begin
            case (state_q)
                S_IDLE: if (uop_valid) begin
                    kind_q  <= uop_kind;
                    op_q    <= uop_op;
                    rd_q    <= uop_rd;
                    opa_q   <= regs[uop_ra];
                    opb_q   <= uop_bsel ? uop_imm : regs[uop_rb];
                    sdata_q <= regs[uop_rb];
                    imm8_q  <= uop_imm[7:0];
                end
                S_EXEC: begin
                    res_q <= alu_res;
                    if (kind_q == K_ALU) begin
                        flag_z_q <= (alu_res == '0);
                        flag_c_q <= alu_c;
                    end
                end
                S_MEM: if (mem_ack && kind_q == K_LOAD) rdata_q <= mem_rdata;
                default: ;
            endcase
        end
    end

    // Writeback lands at the end of WB, so dbg_rdata still shows the old value during done.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            for (int i = 0; i < NREGS; i++) regs[i] <= '0;
        end else if (state_q == S_WB && !wb_skip) begin
            case (kind_q)
                K_ALU:  regs[rd_q]       <= res_q;
                K_LOAD: regs[rd_q]       <= rdata_q;
                K_MOV:  regs[rd_q]       <= sdata_q;
                K_LDLO: regs[rd_q][7:0]  <= imm8_q;
                K_LDHI: regs[rd_q][15:8] <= imm8_q;
                default: ;
            endcase
        end
    end

`ifdef CPU_EXEC_TIMEOUT_EN
    localparam int CW = $clog2(TIMEOUT + 1);
    logic [CW-1:0] tmo_cnt_q;
    logic          tmo_q, err_q;

    // An ack in the expiring cycle takes priority over the timeout.
    assign tmo_hit = (state_q == S_MEM) && !mem_ack && (tmo_cnt_q == CW'(TIMEOUT - 1));

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            tmo_cnt_q <= '0;
            tmo_q     <= 1'b0;
            err_q     <= 1'b0;
        end else begin
            if (state_q == S_MEM && !mem_ack) tmo_cnt_q <= tmo_cnt_q + 1'b1;
            else                              tmo_cnt_q <= '0;
            if (tmo_hit) begin
                tmo_q <= 1'b1;
                err_q <= 1'b1;
            end else if (state_q == S_WB) begin
                tmo_q <= 1'b0;
            end
        end
    end

    assign wb_skip = tmo_q;
    assign err     = err_q;
`else
    assign tmo_hit = 1'b0;
    assign wb_skip = 1'b0;
    assign err     = 1'b0;
`endif

endmodule

// File: tb/tb_cpu_exec_unit.sv
// Randomized bench for cpu_exec_unit against an arithmetic reference model.
module tb_cpu_exec_unit;
    localparam int W  = 16;
    localparam int TO = 4;

    logic          clk = 1'b0;
    logic          reset_n;
    logic          uop_valid, uop_ready, uop_bsel;
    logic [2:0]    uop_kind, uop_op, uop_ra, uop_rb, uop_rd, dbg_raddr;
    logic [W-1:0]  uop_imm, mem_wdata, mem_rdata, dbg_rdata;
    logic [15:0]   mem_addr;
    logic          mem_re, mem_we, mem_ack, done, flag_z, flag_c, err;

    cpu_exec_unit #(.WIDTH(W), .NREGS(8), .ADDR_W(16), .TIMEOUT(TO)) dut (
        .clk(clk), .reset_n(reset_n),
        .uop_valid(uop_valid), .uop_ready(uop_ready),
        .uop_kind(uop_kind), .uop_op(uop_op),
        .uop_ra(uop_ra), .uop_rb(uop_rb), .uop_rd(uop_rd),
        .uop_bsel(uop_bsel), .uop_imm(uop_imm),
        .mem_addr(mem_addr), .mem_wdata(mem_wdata),
        .mem_re(mem_re), .mem_we(mem_we),
        .mem_rdata(mem_rdata), .mem_ack(mem_ack),
        .done(done), .flag_z(flag_z), .flag_c(flag_c), .err(err),
        .dbg_raddr(dbg_raddr), .dbg_rdata(dbg_rdata)
    );

    always #10 clk = ~clk;

    int n_tests = 0;
    int n_fail  = 0;

    logic [15:0] m_reg [8];
    logic        m_z, m_c;
    logic [15:0] mem_m [logic [15:0]];

    task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic check_regs(input string tag);
        for (int i = 0; i < 8; i++) begin
            dbg_raddr = 3'(i);
            #1;
            check_eq(tag, dbg_rdata, m_reg[i]);
        end
    endtask

    task automatic run_uop(input logic [2:0] kind, input logic [2:0] op, input logic [2:0] ra,
                           input logic [2:0] rb, input logic [2:0] rd, input logic bsel,
                           input logic [15:0] imm, input int ack_cyc, input bit hold_valid);
        logic [15:0] a, b, addr, ld, newv, st;
        logic [16:0] s;
        logic        wr, is_mem, z, c;
        int          cyc, memc;
        bit          seen_done;
        a = m_reg[ra];
        b = bsel ? imm : m_reg[rb];
        st = m_reg[rb];
        addr = a + b;
        ld = mem_m.exists(addr) ? mem_m[addr] : 16'($urandom);
        is_mem = (kind == 3'd1) || (kind == 3'd2);
        wr = 1'b1; newv = '0; z = m_z; c = m_c;
        case (kind)
            3'd0: begin
                case (op)
                    3'd0: begin s = {1'b0, a} + {1'b0, b}; newv = s[15:0]; c = s[16]; end
                    3'd1: begin newv = a - b; c = (a >= b); end
                    3'd2: begin newv = a & b; c = 1'b0; end
                    3'd3: begin newv = a | b; c = 1'b0; end
                    3'd4: begin newv = a ^ b; c = 1'b0; end
                    3'd5: begin newv = a * 2; c = a[15]; end
                    3'd6: begin newv = a / 2; c = a[0]; end
                    default: begin newv = b; c = 1'b0; end
                endcase
                z = (newv == 16'h0);
            end
            3'd1: newv = ld;
            3'd2: wr = 1'b0;
            3'd3: newv = {m_reg[rd][15:8], imm[7:0]};
            3'd4: newv = {imm[7:0], m_reg[rd][7:0]};
            3'd5: newv = st;
            default: wr = 1'b0;
        endcase

        @(negedge clk);
        check_eq("uop_ready_idle", uop_ready, 1'b1);
        uop_kind = kind; uop_op = op; uop_ra = ra; uop_rb = rb; uop_rd = rd;
        uop_bsel = bsel; uop_imm = imm; uop_valid = 1'b1; mem_ack = 1'b0;
        cyc = 0; memc = 0; seen_done = 0;
        while (!seen_done && cyc < 40) begin
            @(negedge clk);
            cyc++;
            if (!hold_valid) uop_valid = 1'b0;
            mem_ack = 1'b0;
            mem_rdata = 16'($urandom);
            if (mem_re || mem_we) begin
                memc++;
                check_eq("mem_addr", mem_addr, addr);
                check_eq("mem_re", mem_re, kind == 3'd1);
                check_eq("mem_we", mem_we, kind == 3'd2);
                if (kind == 3'd2) check_eq("mem_wdata", mem_wdata, st);
                if (memc == ack_cyc) begin
                    mem_ack = 1'b1;
                    if (kind == 3'd1) mem_rdata = ld;
                end
            end else if (!done) begin
                mem_ack = 1'($urandom_range(0, 1));
            end
            if (done) begin
                seen_done = 1;
                check_eq("latency", cyc, is_mem ? 2 + ack_cyc : 2);
                dbg_raddr = rd;
                #1;
                check_eq("dbg_old_in_wb", dbg_rdata, m_reg[rd]);
            end
        end
        if (!seen_done) check_eq("done_seen", 0, 1);
        uop_valid = 1'b0;
        mem_ack = 1'b0;
        check_eq("mem_cycles", memc, is_mem ? ack_cyc : 0);
        if (wr) m_reg[rd] = newv;
        if (kind == 3'd2) mem_m[addr] = st;
        m_z = z; m_c = c;
        @(negedge clk);
        check_eq("ready_after", uop_ready, 1'b1);
        check_eq("flag_z", flag_z, m_z);
        check_eq("flag_c", flag_c, m_c);
        check_eq("err_clear", err, 1'b0);
        check_eq("mem_idle", {mem_re, mem_we, done}, 3'b000);
        check_regs("regs");
    endtask

    task automatic reset_mid_mem();
        int n;
        @(negedge clk);
        uop_kind = 3'd1; uop_op = 3'd0; uop_ra = 3'd0; uop_rb = 3'd0; uop_rd = 3'd6;
        uop_bsel = 1'b1; uop_imm = 16'h0040; uop_valid = 1'b1; mem_ack = 1'b0;
        n = 0;
        do begin
            @(negedge clk);
            uop_valid = 1'b0;
            n++;
        end while (!mem_re && n < 10);
        check_eq("reach_mem", mem_re, 1'b1);
        reset_n = 1'b0;
        #1;
        check_eq("rst_mem_re", mem_re, 1'b0);
        check_eq("rst_ready", uop_ready, 1'b1);
        check_eq("rst_flags", {flag_z, flag_c, done, err}, 4'b0000);
        for (int i = 0; i < 8; i++) m_reg[i] = '0;
        m_z = 1'b0; m_c = 1'b0;
        check_regs("rst_regs");
        @(negedge clk);
        reset_n = 1'b1;
    endtask

`ifdef CPU_EXEC_TIMEOUT_EN
    task automatic timeout_test();
        int cyc, memc;
        bit seen_done;
        @(negedge clk);
        uop_kind = 3'd1; uop_op = 3'd0; uop_ra = 3'd0; uop_rb = 3'd0; uop_rd = 3'd5;
        uop_bsel = 1'b1; uop_imm = 16'h0100; uop_valid = 1'b1; mem_ack = 1'b0;
        cyc = 0; memc = 0; seen_done = 0;
        while (!seen_done && cyc < 40) begin
            @(negedge clk);
            uop_valid = 1'b0;
            cyc++;
            if (mem_re) memc++;
            if (done) begin
                seen_done = 1;
                check_eq("tmo_latency", cyc, 2 + TO);
                check_eq("tmo_err", err, 1'b1);
            end
        end
        if (!seen_done) check_eq("tmo_done_seen", 0, 1);
        check_eq("tmo_mem_cycles", memc, TO);
        @(negedge clk);
        check_eq("tmo_err_sticky", err, 1'b1);
        check_eq("tmo_mem_re", mem_re, 1'b0);
        check_regs("tmo_regs");
    endtask
`endif

    initial begin
        reset_n = 1'b0; uop_valid = 1'b0; uop_kind = '0; uop_op = '0;
        uop_ra = '0; uop_rb = '0; uop_rd = '0; uop_bsel = 1'b0; uop_imm = '0;
        mem_rdata = '0; mem_ack = 1'b0; dbg_raddr = '0;
        for (int i = 0; i < 8; i++) m_reg[i] = '0;
        m_z = 1'b0; m_c = 1'b0;
        repeat (3) @(negedge clk);
        check_eq("rst_ready", uop_ready, 1'b1);
        check_eq("rst_mem", {mem_re, mem_we, done, flag_z, flag_c, err}, 6'b0);
        check_eq("rst_addr", mem_addr, 16'h0);
        check_eq("rst_wdata", mem_wdata, 16'h0);
        check_regs("rst_regs");
        reset_n = 1'b1;

        run_uop(3'd3, 3'd0, 3'd0, 3'd0, 3'd1, 1'b1, 16'h0034, 1, 0);
        run_uop(3'd4, 3'd0, 3'd0, 3'd0, 3'd1, 1'b1, 16'h0012, 1, 0);
        dbg_raddr = 3'd1; #1;
        check_eq("r1_1234", dbg_rdata, 16'h1234);
        run_uop(3'd0, 3'd0, 3'd1, 3'd0, 3'd2, 1'b1, 16'hEDCC, 1, 0);
        check_eq("add_zc", {flag_z, flag_c}, 2'b11);
        run_uop(3'd0, 3'd1, 3'd0, 3'd0, 3'd3, 1'b1, 16'h0001, 1, 0);
        dbg_raddr = 3'd3; #1;
        check_eq("sub_ffff", {dbg_rdata, flag_z, flag_c}, {16'hFFFF, 2'b00});
        run_uop(3'd2, 3'd0, 3'd0, 3'd1, 3'd0, 1'b1, 16'h0010, 3, 0);
        mem_m[16'h0010] = 16'hBEEF;
        run_uop(3'd1, 3'd0, 3'd0, 3'd0, 3'd4, 1'b1, 16'h0010, 2, 1);
        dbg_raddr = 3'd4; #1;
        check_eq("r4_beef", dbg_rdata, 16'hBEEF);
        run_uop(3'd1, 3'd0, 3'd0, 3'd0, 3'd7, 1'b1, 16'h0010, 1, 0);

        for (int t = 0; t < 300; t++) begin
            run_uop(3'($urandom_range(0, 7)), 3'($urandom_range(0, 7)),
                    3'($urandom_range(0, 7)), 3'($urandom_range(0, 7)),
                    3'($urandom_range(0, 7)), 1'($urandom_range(0, 1)),
                    ($urandom_range(0, 3) == 0) ? 16'($urandom_range(0, 7)) : 16'($urandom),
                    $urandom_range(1, TO), bit'($urandom_range(0, 1)));
        end

        reset_mid_mem();
        run_uop(3'd3, 3'd0, 3'd0, 3'd0, 3'd2, 1'b1, 16'h00A5, 1, 0);
`ifdef CPU_EXEC_TIMEOUT_EN
        timeout_test();
`endif
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
